// File: rtl/dmem_pkg.sv
// Shared types for the byte-addressed, big-endian data memory with wait states.
package dmem_pkg;

  localparam int unsigned WS_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic        write;
    size_e       size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/data_mem_ws_if.sv
// Request/response bus between the MEM stage and the data memory.
interface data_mem_ws_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_byte_array.sv
// 2^ADDR_W bytes stored as four byte lanes; lane 0 holds the byte at offset 0
// (the most significant byte of a big-endian word). Contents are never reset.
module dmem_byte_array #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-3:0] i_idx,
  input  logic [3:0]        i_we,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  localparam int unsigned DEPTH = 1 << (ADDR_W - 2);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (i_we[g]) r_mem[i_idx] <= i_wdata[31-8*g -: 8];
    end

    assign o_rdata[31-8*g -: 8] = r_mem[i_idx];
  end

endmodule

// File: rtl/data_mem_ws.sv
// Byte-addressed big-endian data memory with lb/lbu/lh/lhu/lw/sb/sh/sw support,
// valid/ready requests, a one-cycle response pulse and WAIT_STATES wait cycles.
module data_mem_ws
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  data_mem_ws_if.slave bus
);

  localparam logic [31:0]     HI_MASK = ~((32'd1 << ADDR_W) - 32'd1);
  localparam logic [WS_W-1:0] WS_LOAD = WS_W'(WAIT_STATES);

  state_e          r_state;
  logic [WS_W-1:0] r_cnt;
  req_t            r_req;
  logic            r_resp_valid;
  logic [31:0]     r_resp_rdata;
  logic            r_resp_err;

  req_t        w_req;
  logic        w_accept;
  logic        w_commit;
  logic        w_err;
  logic [1:0]  w_off;
  logic [3:0]  w_we;
  logic [3:0]  w_lane_we;
  logic [31:0] w_wd;
  logic [31:0] w_rd;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;

  assign w_accept = bus.req_valid && (r_state == IDLE);

  // With zero wait states the access commits on the accept edge itself, so the
  // datapath must see the live request in IDLE and the latched one afterwards.
  always_comb begin
    w_req = r_req;
    if (r_state == IDLE) begin
      w_req.write = bus.req_write;
      w_req.size  = size_e'(bus.req_size);
      w_req.uns   = bus.req_unsigned;
      w_req.addr  = bus.req_addr;
      w_req.wdata = bus.req_wdata;
    end
  end

  always_comb begin
    w_commit = 1'b0;
    if (rst_n) begin
      case (r_state)
        IDLE:    w_commit = w_accept && (WAIT_STATES == 0);
        WAIT:    w_commit = (r_cnt == WS_W'(1));
        default: w_commit = 1'b0;
      endcase
    end
  end

  assign w_off = w_req.addr[1:0];

  always_comb begin
    w_err = (|(w_req.addr & HI_MASK)) || (w_req.size == SZ_ILL);
    if (w_req.size == SZ_HALF && w_off[0])   w_err = 1'b1;
    if (w_req.size == SZ_WORD && (|w_off))   w_err = 1'b1;
  end

  always_comb begin
    w_we = '0;
    w_wd = '0;
    case (w_req.size)
      SZ_BYTE: begin
        w_we = 4'b0001 << w_off;
        w_wd = {4{w_req.wdata[7:0]}};
      end
      SZ_HALF: begin
        w_we = w_off[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{w_req.wdata[15:0]}};
      end
      SZ_WORD: begin
        w_we = '1;
        w_wd = w_req.wdata;
      end
      default: ;
    endcase
  end

  assign w_lane_we = (w_commit && w_req.write && !w_err) ? w_we : '0;

  dmem_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .i_idx   (w_req.addr[ADDR_W-1:2]),
    .i_we    (w_lane_we),
    .i_wdata (w_wd),
    .o_rdata (w_rd)
  );

  always_comb begin
    case (w_off)
      2'd0:    w_byte = w_rd[31:24];
      2'd1:    w_byte = w_rd[23:16];
      2'd2:    w_byte = w_rd[15:8];
      default: w_byte = w_rd[7:0];
    endcase
    w_half = w_off[1] ? w_rd[15:0] : w_rd[31:16];
    case (w_req.size)
      SZ_BYTE: w_ld = w_req.uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_ld = w_req.uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ld = w_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_commit) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= (w_err || w_req.write) ? '0 : w_ld;
      end
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req <= w_req;
            if (WAIT_STATES == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WS_LOAD;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - WS_W'(1);
          if (r_cnt == WS_W'(1)) r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule
